seg4x7_scroll_writer: RTL



---
 rtl/seg4x7_scroll_writer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seg4x7_scroll_writer.sv
// ASCII scroll producer for the 4-digit 7-segment driver: FIFO-buffered char stream shifted right-to-left.
// Define SEG_SCROLL_UPCASE_EN to fold lowercase letters to uppercase when they are written into the FIFO.
module seg4x7_scroll_writer #(
   parameter int SCROLL_DIV = 25000000,
   parameter int FIFO_AW    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         char_data,
   input  logic               char_valid,
   output logic               char_ready,
   input  logic               pause,
   input  logic               flush,
   output logic [31:0]        text,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               scroll_tick,
   output logic               idle
);

   // state     | meaning
   // ST_IDLE   | window blank, waiting for the first character
   // ST_SCROLL | stepping the window every SCROLL_DIV cycles

   localparam int            DEPTH  = 2**FIFO_AW;
   localparam int            TW     = $clog2(SCROLL_DIV);
   localparam logic [TW-1:0] TERM   = TW'(SCROLL_DIV - 1);
   localparam logic [7:0]    SPACE  = 8'h20;
   localparam logic [31:0]   BLANKS = 32'h20202020;

   typedef enum logic {ST_IDLE = 1'b0, ST_SCROLL = 1'b1} state_t;

   state_t             state;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [TW-1:0]      timer;
   logic [2:0]         blank_cnt;
   logic               full;
   logic               empty;
   logic               push;
   logic               pop;
   logic [7:0]         wr_char;
   logic [7:0]         rd_char;

   assign full       = (fifo_level == (FIFO_AW+1)'(DEPTH));
   assign empty      = (fifo_level == '0);
   assign char_ready = !full && !flush;
   assign push       = char_valid && char_ready;
   assign rd_char    = mem[rd_ptr];

   // A pop only ever happens together with a shift, and never from an empty FIFO.
   always_comb begin
      pop = 1'b0;
      if (!flush && !pause && !empty) begin
         if (state == ST_IDLE)
            pop = 1'b1;
         else if (timer == TERM)
            pop = 1'b1;
      end
   end

   always_comb begin
      wr_char = char_data;
`ifdef SEG_SCROLL_UPCASE_EN
      if (char_data >= 8'h61 && char_data <= 8'h7A)
         wr_char = char_data - 8'h20;
`endif
   end

   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr] <= wr_char;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state       <= ST_IDLE;
         timer       <= '0;
         blank_cnt   <= '0;
         text        <= BLANKS;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_level  <= '0;
         scroll_tick <= 1'b0;
         idle        <= 1'b1;
      end else begin
         scroll_tick <= 1'b0;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase

         case (state)
            ST_IDLE: begin
               timer <= '0;
               idle  <= 1'b1;
               if (!empty && !pause) begin
                  text        <= {text[23:0], rd_char};
                  scroll_tick <= 1'b1;
                  blank_cnt   <= '0;
                  state       <= ST_SCROLL;
                  idle        <= 1'b0;
               end
            end
            ST_SCROLL: begin
               if (!pause) begin
                  if (timer == TERM) begin
                     timer       <= '0;
                     scroll_tick <= 1'b1;
                     text        <= {text[23:0], empty ? SPACE : rd_char};
                     if (!empty) begin
                        blank_cnt <= '0;
                     end else begin
                        blank_cnt <= blank_cnt + 1'b1;
                        // Fourth consecutive blank pushes the last char off the left edge.
                        if (blank_cnt == 3'd3) begin
                           state <= ST_IDLE;
                           idle  <= 1'b1;
                        end
                     end
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
